// File: rtl/xbar_pkg.sv
// Shared constants and types for the up/down crossbar shift stages of the
// convolution datapath.
package xbar_pkg;

  localparam int XBAR_LANES  = 16;
  localparam int XBAR_WIDTH  = 32;
  localparam int XBAR_STEP   = 2;
  localparam int XBAR_PHASES = 4;

  localparam int XBAR_SHW = $clog2(XBAR_LANES);
  localparam int XBAR_PHW = $clog2(XBAR_PHASES);

  typedef logic [XBAR_WIDTH-1:0] lane_t;
  typedef logic [XBAR_PHW-1:0]   phase_t;

  // Rotation distance for a phase; lanes is a power of two, so the mod is exact.
  function automatic int rot_amount(input int step, input int phase, input int lanes);
    return (step * phase) % lanes;
  endfunction

endpackage

// File: rtl/crossbar_rotate_down.sv
// Combinational barrel rotate: output lane i takes input lane (i - amt) mod LANES.
module crossbar_rotate_down #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
) (
  input  logic [LANES*WIDTH-1:0]   in_bus,
  input  logic [$clog2(LANES)-1:0] amt,
  output logic [LANES*WIDTH-1:0]   out_bus
);

  localparam int SW = $clog2(LANES);

  logic [SW-1:0] src;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    out_bus = '0;
    src     = '0;
    for (int i = 0; i < LANES; i++) begin
      src = SW'(i) - amt;
      out_bus[i*WIDTH +: WIDTH] = in_bus[int'(src)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/crossbar_shift_down.sv
// Down-shifting crossbar stage: registers the input bus rotated down by STEP*phase.
// Optional synchronous phase restart port io_clear under CROSSBAR_SHIFT_DOWN_CLEAR_EN.
module crossbar_shift_down
  import xbar_pkg::*;
#(
  parameter int LANES  = XBAR_LANES,
  parameter int WIDTH  = XBAR_WIDTH,
  parameter int STEP   = XBAR_STEP,
  parameter int PHASES = XBAR_PHASES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      io_clk_en,
  input  logic                      io_start,
`ifdef CROSSBAR_SHIFT_DOWN_CLEAR_EN
  input  logic                      io_clear,
`endif
  input  logic [LANES*WIDTH-1:0]    io_in,
  output logic [LANES*WIDTH-1:0]    io_out,
  output logic                      io_out_valid,
  output logic                      io_last,
  output logic [$clog2(PHASES)-1:0] io_phase,
  output logic                      io_start_next_stage
);

  localparam int SW = $clog2(LANES);
  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

  logic                   fire;
  logic                   clear_req;
  logic [SW-1:0]          amt;
  logic [LANES*WIDTH-1:0] rot_bus;

  logic [LANES*WIDTH-1:0] out_d, out_q;
  logic [PW-1:0]          phase_d, phase_q;
  logic                   valid_d, valid_q;
  logic                   last_d, last_q;
  logic                   sns_d, sns_q;

  assign fire = io_clk_en & io_start;

`ifdef CROSSBAR_SHIFT_DOWN_CLEAR_EN
  assign clear_req = io_clear;
`else
  assign clear_req = 1'b0;
`endif

  assign amt = SW'(rot_amount(STEP, int'(phase_q), LANES));

  crossbar_rotate_down #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_rotate (
    .in_bus  (io_in),
    .amt     (amt),
    .out_bus (rot_bus)
  );

  always_comb begin
    out_d   = out_q;
    phase_d = phase_q;
    sns_d   = sns_q;
    valid_d = fire;
    last_d  = fire && (phase_q == LAST_PHASE);
    if (fire) begin
      out_d   = rot_bus;
      sns_d   = 1'b1;
      phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
    end
    // Clear wins over the increment but never blocks the capture itself.
    if (clear_req) begin
      phase_d = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments; the wide data register is
  // reset too because downstream write-back observes io_out right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sns_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      sns_q   <= sns_d;
    end
  end

  assign io_out              = out_q;
  assign io_out_valid        = valid_q;
  assign io_last             = last_q;
  assign io_phase            = phase_q;
  assign io_start_next_stage = sns_q;

endmodule

// File: tb/tb_crossbar_shift_down.sv
// Scoreboard bench for crossbar_shift_down: stimulus pushes expectations, a
// negedge monitor pops and compares whenever io_out_valid is presented.
module tb_crossbar_shift_down;
  import xbar_pkg::*;

  localparam int L  = XBAR_LANES;
  localparam int W  = XBAR_WIDTH;
  localparam int P  = XBAR_PHASES;
  localparam int PW = $clog2(XBAR_PHASES);
  localparam int BW = L * W;

  typedef logic [BW-1:0] bus_t;
  typedef struct {
    bus_t          out;
    logic          last;
    logic [PW-1:0] phase;
    logic          sns;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_clk_en;
  logic          io_start;
  logic          io_clear;
  bus_t          io_in;
  bus_t          io_out;
  logic          io_out_valid;
  logic          io_last;
  logic [PW-1:0] io_phase;
  logic          io_start_next_stage;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_phase;
  bus_t m_out;
  bus_t x_vec;
  bus_t base_in;

  int   h_lane0[4] = '{0, 14, 12, 10};
  int   h_lane2[4] = '{2, 0, 14, 12};

  always #5 clk = ~clk;

  crossbar_shift_down dut (
    .clk                 (clk),
    .reset               (reset),
    .io_clk_en           (io_clk_en),
    .io_start            (io_start),
`ifdef CROSSBAR_SHIFT_DOWN_CLEAR_EN
    .io_clear            (io_clear),
`endif
    .io_in               (io_in),
    .io_out              (io_out),
    .io_out_valid        (io_out_valid),
    .io_last             (io_last),
    .io_phase            (io_phase),
    .io_start_next_stage (io_start_next_stage)
  );

  task automatic check(input string name, input bus_t act, input bus_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bus_t rot_down(input bus_t b, input int amt);
    bus_t r;
    r = '0;
    for (int i = 0; i < L; i++) r[i*W +: W] = b[((i - amt) & (L - 1))*W +: W];
    return r;
  endfunction

  function automatic bus_t rot_up(input bus_t b, input int t);
    bus_t r;
    r = '0;
    for (int i = 0; i < L; i++) r[i*W +: W] = b[((i + XBAR_STEP*t) & (L - 1))*W +: W];
    return r;
  endfunction

  // Issue one fire at a negedge, record its expectation, wait for the capture.
  task automatic fire_step(input logic clr);
    exp_t e;
    e.out   = rot_down(io_in, XBAR_STEP * m_phase);
    e.last  = (m_phase == P - 1);
    e.phase = clr ? '0 : PW'((m_phase + 1) % P);
    e.sns   = 1'b1;
    sb_q.push_back(e);
    m_out   = e.out;
    m_phase = int'(e.phase);
    io_start = 1'b1;
    io_clear = clr;
    @(negedge clk);
    io_start = 1'b0;
    io_clear = 1'b0;
  endtask

  always @(negedge clk) begin
    if (io_out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_out",   io_out,              mon_e.out);
        check("sb_last",  io_last,             mon_e.last);
        check("sb_phase", io_phase,            mon_e.phase);
        check("sb_sns",   io_start_next_stage, mon_e.sns);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int j = 0; j < L; j++) base_in[j*W +: W] = W'(j);
    reset = 1'b1; io_clk_en = 1'b1; io_start = 1'b0; io_clear = 1'b0;
    io_in = base_in; m_phase = 0; m_out = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: nothing changes.
    repeat (5) @(negedge clk);
    check("idle_out",   io_out,              0);
    check("idle_phase", io_phase,            0);
    check("idle_sns",   io_start_next_stage, 0);
    check("idle_valid", io_out_valid,        0);

    // Four back-to-back fires through every phase.
    for (int k = 0; k < 4; k++) begin
      fire_step(1'b0);
      check("seq_lane0", io_out[0*W +: W], h_lane0[k]);
      check("seq_lane2", io_out[2*W +: W], h_lane2[k]);
      check("seq_sns",   io_start_next_stage, 1);
    end
    check("wrap_phase", io_phase, 0);

    @(negedge clk);
    check("gap_valid", io_out_valid, 0);
    check("gap_last",  io_last,      0);

    // Fifth fire after wrap uses phase 0 again.
    fire_step(1'b0);
    check("wrap_lane0", io_out[0*W +: W], 0);
    check("wrap_valid", io_out_valid,     1);

    // Freeze at phase 2 with start held high.
    fire_step(1'b0);
    io_clk_en = 1'b0;
    io_start  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("frz_phase", io_phase,     2);
      check("frz_out",   io_out,       m_out);
      check("frz_valid", io_out_valid, 0);
    end
    io_start  = 1'b0;
    io_clk_en = 1'b1;

    // Reset at phase 3 coinciding with a fire.
    fire_step(1'b0);
    check("pre_rst_phase", io_phase, 3);
    reset    = 1'b1;
    io_start = 1'b1;
    @(negedge clk);
    check("rst_out",   io_out,              0);
    check("rst_phase", io_phase,            0);
    check("rst_valid", io_out_valid,        0);
    check("rst_last",  io_last,             0);
    check("rst_sns",   io_start_next_stage, 0);
    reset = 1'b0; io_start = 1'b0; m_phase = 0;
    @(negedge clk);

    // Round trip through an up-stage model.
    for (int j = 0; j < L; j++) x_vec[j*W +: W] = W'($urandom);
    for (int t = 0; t < 4; t++) begin
      io_in = rot_up(x_vec, t);
      fire_step(1'b0);
      check("rt_out", io_out, x_vec);
    end
    io_in = base_in;

`ifdef CROSSBAR_SHIFT_DOWN_CLEAR_EN
    fire_step(1'b0);
    fire_step(1'b0);
    check("clr_pre_phase", io_phase, 2);
    io_clear = 1'b1;
    @(negedge clk);
    io_clear = 1'b0;
    m_phase  = 0;
    check("clr_phase", io_phase, 0);
    fire_step(1'b0);
    check("clr_lane0", io_out[0*W +: W], 0);
    fire_step(1'b1);
    check("clr_fire_lane0", io_out[0*W +: W], 14);
    check("clr_fire_phase", io_phase,         0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crossbar_shift_down.md
# crossbar_shift_down

- Inverse of the up-shifting crossbar stage in the convolution datapath.
- Each enabled start step registers a copy of the 16-lane input bus, rotated *down* by `STEP × phase` lanes.
- Restores the original lane order after an up-shift stage applied the same phase sequence.
- Sits at the output side of the PE array, before write-back to the feature-map buffer.

## Interface
- `LANES`, 16, number of lanes; power of two.
- `WIDTH`, 32, bits per lane.
- `STEP`, 2, lane rotation added per phase.
- `PHASES`, 4, phases per sequence; `PHASES*STEP < LANES`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `io_clk_en`  in  1  global step enable.
- `io_start`  in  1  step request. A step fires when `io_clk_en & io_start`.
- `io_clear`  in  1  synchronous phase restart. Present only with `CROSSBAR_SHIFT_DOWN_CLEAR_EN`.
- `io_in`  in  `LANES*WIDTH`  input lanes; lane j = `[j*WIDTH +: WIDTH]`.
- `io_out`  out  `LANES*WIDTH`  registered output lanes, same packing.
- `io_out_valid`  out  1  one-cycle pulse: `io_out` was updated by the last edge.
- `io_last`  out  1  one-cycle pulse: the last edge captured phase `PHASES-1`.
- `io_phase`  out  `$clog2(PHASES)`  current phase counter value.
- `io_start_next_stage`  out  1  sticky flag: at least one step has fired since reset.

## Operation
- Step: `fire = io_clk_en & io_start`.
- On fire with phase counter p:
  - output lane i ← `io_in` lane `(i − STEP*p) mod LANES`.
  - Modulo is taken on `$clog2(LANES)`-bit unsigned arithmetic.
- Phase counter:
  - Increments on fire.
  - Wraps from `PHASES-1` to 0.
  - Holds when there is no fire.
- No fire: `io_out` holds its value; `io_out_valid` and `io_last` are 0 on the next cycle.
- `io_start_next_stage` is set on the first fire and cleared only by `reset`.
- `io_clk_en=0` freezes all state, including the phase counter. This holds even when `io_start=1`.
- State machine: the phase counter is the only state (IDLE is p=0 with no fire). There is no other FSM.
- Round trip: up-stage phase t gives `u[i]=x[(i+STEP*t)]`; this block then gives `d[i]=u[(i−STEP*t)]=x[i]`.

## Timing
- Latency: 1 cycle from a fire edge to `io_out` / `io_out_valid` / `io_last`.
- Throughput: one step per cycle; back-to-back fires are legal.
- Reset values: `io_out`=0, `io_out_valid`=0, `io_last`=0, `io_phase`=0, `io_start_next_stage`=0.
- `reset` mid-sequence:
  - All of the above return to their reset values on the next edge.
  - A fire in the same cycle is ignored.
- `io_phase` is registered. It shows the phase that the *next* fire will use.

## Configuration
- `CROSSBAR_SHIFT_DOWN_CLEAR_EN` defined:
  - The `io_clear` port exists.
  - `io_clear=1` sets the phase to 0 on the next edge, regardless of fire. Clear takes priority over the increment.
  - If fire and clear coincide, the capture still occurs using the current phase, and `io_out_valid` still pulses.
  - `io_out` and `io_start_next_stage` are unaffected by clear.
- Undefined: the port is absent; the phase is cleared only by `reset` or wrap.

## Structure
- Shared package `xbar_pkg`:
  - `XBAR_LANES`, `XBAR_WIDTH`, `XBAR_STEP`, `XBAR_PHASES` default constants.
  - `lane_t` typedef (`WIDTH` bits).
  - `phase_t` typedef. The up-stage uses the same package.
- Sub-module `crossbar_rotate_down`:
  - Purely combinational barrel rotate by a `$clog2(LANES)`-bit amount.
  - The top module holds the counter, flags and output register.

## Test plan
Defaults; `io_in` lane j = j.
1. After reset, hold `io_clk_en=1`, `io_start=0` for 5 cycles → `io_out`=0, `io_phase`=0, `io_start_next_stage`=0.
2. Four consecutive fires → `io_out` lane 0 is 0, 14, 12, 10 in successive cycles; lane 2 is 2, 0, 14, 12. `io_last` pulses only after the 4th fire; `io_start_next_stage`=1 from the first edge on.
3. Fifth fire → wrap: `io_phase`=0 before the capture, lane 0=0, `io_out_valid`=1, `io_last`=0.
4. `io_start=1`, `io_clk_en=0` for 3 cycles at phase 2 → `io_phase` stays 2, `io_out` is unchanged, `io_out_valid`=0.
5. `reset` asserted at phase 3 together with a fire → next cycle `io_out`=0, `io_phase`=0, all flags 0.
6. Round trip: random x through an up-stage then this block, 4 fires with matching phases → output equals x on every lane. With `CROSSBAR_SHIFT_DOWN_CLEAR_EN`: clear at phase 2 → the next fire uses phase 0.
